// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int SUB_WIDTH_DEFAULT = 4;

  // Counter must reach WIDTH, hence WIDTH+1 distinct values
  function automatic int sub_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (A - B, LSB first) with parallel result.
// Define SERIAL_SUBTRACTOR_OVF_EN to build the signed overflow flag; otherwise ovf is tied to 0.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CNT_W = sub_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bq_q, bq_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic             fs_d, fs_bout;

  full_subtractor u_fs (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .bin  (bq_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    diff_d    = diff_q;
    cnt_d     = cnt_q;
    bq_d      = bq_q;
    borrow_d  = borrow_q;
    bit_out   = 1'b0;
    bit_valid = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;

    case (state_q)
      IDLE: begin
        accept = start;
      end
      SHIFT: begin
        bit_out   = fs_d;
        bit_valid = 1'b1;
        bq_d      = fs_bout;
        opa_d     = opa_q >> 1;
        opb_d     = opb_q >> 1;
        res_d     = {fs_d, res_q[WIDTH-1:1]};
        cnt_d     = cnt_q + CNT_W'(1);
        // Result registers are loaded on the edge into DONE so they are valid with done
        if (cnt_q == LAST_BIT) begin
          state_d  = DONE;
          diff_d   = {fs_d, res_q[WIDTH-1:1]};
          borrow_d = fs_bout;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
        accept  = start;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      opa_d   = a;
      opb_d   = b;
      bq_d    = 1'b0;
      cnt_d   = '0;
      state_d = SHIFT;
    end

    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bq_q     <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bq_q     <= bq_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // Operand MSBs are captured at start because opa/opb are shifted away during SHIFT
  logic opa_msb_q, opa_msb_d;
  logic opb_msb_q, opb_msb_d;
  logic ovf_q, ovf_d;

  always_comb begin
    opa_msb_d = opa_msb_q;
    opb_msb_d = opb_msb_q;
    ovf_d     = ovf_q;
    if (accept) begin
      opa_msb_d = a[WIDTH-1];
      opb_msb_d = b[WIDTH-1];
    end
    if (state_q == SHIFT && cnt_q == LAST_BIT) begin
      ovf_d = (opa_msb_q != opb_msb_q) && (fs_d != opa_msb_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa_msb_q <= 1'b0;
      opb_msb_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      opa_msb_q <= opa_msb_d;
      opb_msb_q <= opb_msb_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy   = busy_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): directed cases plus random operands vs an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, bit_out, bit_valid, done, borrow, ovf;
  logic [W-1:0] diff;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .done      (done),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                output logic [W-1:0] ed, output logic eb, output logic eo);
    int sa, sb, sd;
    ed = W'(int'(av) - int'(bv));
    eb = (av < bv);
    sa = (av >= 8) ? int'(av) - 16 : int'(av);
    sb = (bv >= 8) ? int'(bv) - 16 : int'(bv);
    sd = sa - sb;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    eo = (sd > 7) || (sd < -8);
`else
    eo = 1'b0;
`endif
  endfunction

  // One full operation: start pulse, 4 serial bits, done cycle, return to idle
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W-1:0] ed;
    logic eb, eo;
    model(av, bv, ed, eb, eo);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      checkOutput("busy_shift", busy, 1);
      checkOutput("bit_valid_shift", bit_valid, 1);
      checkOutput($sformatf("bit_out[%0d] %0d-%0d", i, av, bv), bit_out, ed[i]);
      checkOutput("done_shift", done, 0);
      @(negedge clk);
    end
    checkOutput("done_pulse", done, 1);
    checkOutput("busy_done", busy, 0);
    checkOutput("bit_valid_done", bit_valid, 0);
    checkOutput($sformatf("diff %0d-%0d", av, bv), diff, ed);
    checkOutput($sformatf("borrow %0d-%0d", av, bv), borrow, eb);
    checkOutput($sformatf("ovf %0d-%0d", av, bv), ovf, eo);
    @(negedge clk);
    checkOutput("done_cleared", done, 0);
    checkOutput("busy_idle", busy, 0);
    checkOutput("bit_out_idle", bit_out, 0);
    checkOutput("diff_hold", diff, ed);
    checkOutput("borrow_hold", borrow, eb);
  endtask

  initial begin
    logic [W-1:0] ed;
    logic eb, eo;
    int done_seen;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_bit_valid", bit_valid, 0);
    checkOutput("rst_bit_out", bit_out, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_diff", diff, 0);
    checkOutput("rst_borrow", borrow, 0);
    checkOutput("rst_ovf", ovf, 0);
    rst_n = 1'b1;

    applyStimulus(4'd9, 4'd3);
    applyStimulus(4'd3, 4'd9);
    applyStimulus(4'd7, 4'd8);
    applyStimulus(4'd0, 4'd0);
    applyStimulus(4'd0, 4'd15);
    applyStimulus(4'd8, 4'd1);

    // start held high: a new operation begins in every DONE cycle
    @(negedge clk);
    a = 4'd5; b = 4'd5; start = 1'b1;
    for (int j = 1; j <= 15; j++) begin
      @(negedge clk);
      checkOutput($sformatf("b2b_done c%0d", j), done, (j % 5) == 0);
      checkOutput($sformatf("b2b_busy c%0d", j), busy, (j % 5) != 0);
      if ((j % 5) == 0) begin
        checkOutput("b2b_diff", diff, 0);
        checkOutput("b2b_borrow", borrow, 0);
      end
    end
    start = 1'b0;
    repeat (6) @(negedge clk);

    // start and operand changes during SHIFT must be ignored
    model(4'd12, 4'd5, ed, eb, eo);
    a = 4'd12; b = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd1; b = 4'd14; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("ignore_done", done, 1);
    checkOutput("ignore_diff", diff, ed);
    checkOutput("ignore_borrow", borrow, eb);
    checkOutput("ignore_ovf", ovf, eo);
    @(negedge clk);
    checkOutput("ignore_no_restart", busy, 0);

    // reset during the second SHIFT cycle aborts and clears results
    a = 4'd10; b = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_bit_valid", bit_valid, 0);
    checkOutput("abort_diff", diff, 0);
    checkOutput("abort_borrow", borrow, 0);
    done_seen = 0;
    for (int j = 0; j < 8; j++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    checkOutput("abort_no_done", done_seen, 0);
    applyStimulus(4'd10, 4'd2);

    for (int n = 0; n < 20; n++) begin
      applyStimulus(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
